// File: rtl/scoreboard_pkg.sv
// Shared defaults and FSM state type for the register scoreboard.
package scoreboard_pkg;

   localparam int SB_NREGS = 32;
   localparam int SB_AW    = 5;
   localparam int SB_CW    = 2;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } sb_state_e;

endpackage

// File: rtl/sb_reg_counter.sv
// Per-register in-flight write counter; saturates at 2^CW-1 and refuses to
// decrement below zero, reporting the attempt on underflow.
module sb_reg_counter import scoreboard_pkg::*; #(
   parameter int CW = SB_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          inc_done,
   output logic          dec_done,
   output logic          underflow
);

   localparam logic [CW-1:0] MAXP = '1;

   assign inc_done  = inc && (count != MAXP);
   assign dec_done  = dec && (count != '0);
   assign underflow = dec && (count == '0);

   // A simultaneous increment and decrement cancel and leave the count alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc_done && !dec_done)
         count <= count + 1'b1;
      else if (dec_done && !inc_done)
         count <= count - 1'b1;
   end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard: tracks pending register writes and gates issue on
// RAW/overflow hazards. Optional feature macro: SB_WB_BYPASS_EN.
module reg_scoreboard import scoreboard_pkg::*; #(
   parameter int NREGS = SB_NREGS,
   parameter int AW    = SB_AW,
   parameter int CW    = SB_CW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [AW-1:0]    issue_rs,
   input  logic [AW-1:0]    issue_rt,
   input  logic             issue_rs_used,
   input  logic             issue_rt_used,
   input  logic [AW-1:0]    issue_rd,
   input  logic             issue_rd_wr,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_rd,
   input  logic             drain_req,
   output logic             drain_done,
   input  logic             flush,
   output logic [NREGS-1:0] busy_mask,
   output logic [AW+CW-1:0] outstanding,
   output logic             err_underflow
);

   localparam int OW = AW + CW;
   localparam logic [CW-1:0] MAXP    = '1;
   localparam logic [OW-1:0] OUT_ONE = OW'(1);

   sb_state_e state;

   logic [NREGS-1:0][CW-1:0] cnt;
   logic [NREGS-1:1]         inc_vec, dec_vec;
   logic [NREGS-1:1]         inc_done_vec, dec_done_vec, uf_vec;
   logic [CW-1:0]            rs_cnt, rt_cnt;
   logic                     rs_haz, rt_haz, rd_haz;
   logic                     issue_fire, inc_any, dec_any;

   assign cnt[0] = '0;

   // Source counts seen by the hazard check; the bypass variant credits a
   // writeback landing this cycle so the consumer can issue alongside it.
   always_comb begin
      rs_cnt = cnt[issue_rs];
      rt_cnt = cnt[issue_rt];
`ifdef SB_WB_BYPASS_EN
      if (wb_valid && (wb_rd == issue_rs) && (rs_cnt != '0))
         rs_cnt = rs_cnt - 1'b1;
      if (wb_valid && (wb_rd == issue_rt) && (rt_cnt != '0))
         rt_cnt = rt_cnt - 1'b1;
`endif
   end

   assign rs_haz = issue_rs_used && (issue_rs != '0) && (rs_cnt != '0);
   assign rt_haz = issue_rt_used && (issue_rt != '0) && (rt_cnt != '0);
   assign rd_haz = issue_rd_wr && (issue_rd != '0) && (cnt[issue_rd] == MAXP);

   assign issue_ready = (state == ST_RUN) && !rs_haz && !rt_haz && !rd_haz && !flush;
   assign issue_fire  = issue_valid && issue_ready;

   for (genvar i = 1; i < NREGS; i++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(i);

      assign inc_vec[i] = issue_fire && issue_rd_wr && (issue_rd == IDX);
      assign dec_vec[i] = wb_valid && !flush && (wb_rd == IDX);

      sb_reg_counter #(.CW(CW)) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .clr       (flush),
         .inc       (inc_vec[i]),
         .dec       (dec_vec[i]),
         .count     (cnt[i]),
         .inc_done  (inc_done_vec[i]),
         .dec_done  (dec_done_vec[i]),
         .underflow (uf_vec[i])
      );
   end

   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < NREGS; i++)
         busy_mask[i] = (cnt[i] != '0);
   end

   assign inc_any = |inc_done_vec;
   assign dec_any = |dec_done_vec;

   // Running total kept in lockstep with the counters instead of an adder tree.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         outstanding <= '0;
      else if (flush)
         outstanding <= '0;
      else if (inc_any && !dec_any)
         outstanding <= outstanding + OUT_ONE;
      else if (dec_any && !inc_any)
         outstanding <= outstanding - OUT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_underflow <= 1'b0;
      else if (|uf_vec)
         err_underflow <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_RUN;
         drain_done <= 1'b0;
      end else begin
         drain_done <= 1'b0;
         case (state)
            ST_RUN: begin
               if (drain_req)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if ((outstanding == '0) || flush) begin
                  state      <= ST_RUN;
                  drain_done <= 1'b1;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a per-register array model checked
// every cycle, plus hand-computed literal expectations.
module tb_reg_scoreboard;

   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int CW    = 2;
   localparam int MAXP  = 3;
`ifdef SB_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             issue_valid, issue_ready;
   logic [AW-1:0]    issue_rs, issue_rt, issue_rd, wb_rd;
   logic             issue_rs_used, issue_rt_used, issue_rd_wr, wb_valid;
   logic             drain_req, drain_done, flush, err_underflow;
   logic [NREGS-1:0] busy_mask;
   logic [AW+CW-1:0] outstanding;

   int tests = 0;
   int fails = 0;

   int cnt_m [NREGS];
   bit drain_m = 1'b0;
   bit err_m   = 1'b0;
   bit done_m  = 1'b0;

   always #5 clk = ~clk;

   reg_scoreboard #(.NREGS(NREGS), .AW(AW), .CW(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_rs      (issue_rs),
      .issue_rt      (issue_rt),
      .issue_rs_used (issue_rs_used),
      .issue_rt_used (issue_rt_used),
      .issue_rd      (issue_rd),
      .issue_rd_wr   (issue_rd_wr),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .drain_req     (drain_req),
      .drain_done    (drain_done),
      .flush         (flush),
      .busy_mask     (busy_mask),
      .outstanding   (outstanding),
      .err_underflow (err_underflow)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int eff(input int r);
      int c;
      c = cnt_m[r];
      if (BYP && wb_valid && int'(wb_rd) == r && c > 0)
         c--;
      return c;
   endfunction

   function automatic bit exp_ready();
      bit rs_h, rt_h, rd_h;
      rs_h = issue_rs_used && issue_rs != 0 && eff(int'(issue_rs)) != 0;
      rt_h = issue_rt_used && issue_rt != 0 && eff(int'(issue_rt)) != 0;
      rd_h = issue_rd_wr && issue_rd != 0 && cnt_m[issue_rd] == MAXP;
      return !drain_m && !flush && !rs_h && !rt_h && !rd_h;
   endfunction

   function automatic int sum_m();
      int s = 0;
      for (int i = 0; i < NREGS; i++) s += cnt_m[i];
      return s;
   endfunction

   function automatic logic [NREGS-1:0] mask_m();
      logic [NREGS-1:0] m = '0;
      for (int i = 0; i < NREGS; i++) m[i] = (cnt_m[i] != 0);
      return m;
   endfunction

   // Model state advance on each edge (or on reset assertion).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) cnt_m[i] = 0;
         drain_m = 1'b0;
         err_m   = 1'b0;
         done_m  = 1'b0;
      end else begin
         bit acc;
         int tot;
         acc    = issue_valid && exp_ready();
         tot    = sum_m();
         done_m = 1'b0;
         if (drain_m) begin
            if (tot == 0 || flush) begin
               drain_m = 1'b0;
               done_m  = 1'b1;
            end
         end else if (drain_req) begin
            drain_m = 1'b1;
         end
         if (flush) begin
            for (int i = 0; i < NREGS; i++) cnt_m[i] = 0;
         end else begin
            if (wb_valid && wb_rd != 0) begin
               if (cnt_m[wb_rd] == 0) err_m = 1'b1;
               else cnt_m[wb_rd]--;
            end
            if (acc && issue_rd_wr && issue_rd != 0)
               cnt_m[issue_rd]++;
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_issue_ready", issue_ready, exp_ready());
      chk("cyc_busy_mask", busy_mask, mask_m());
      chk("cyc_outstanding", outstanding, sum_m());
      chk("cyc_err_underflow", err_underflow, err_m);
      chk("cyc_drain_done", drain_done, done_m);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid   = 1'b0;
      issue_rs      = '0;
      issue_rt      = '0;
      issue_rs_used = 1'b0;
      issue_rt_used = 1'b0;
      issue_rd      = '0;
      issue_rd_wr   = 1'b0;
      wb_valid      = 1'b0;
      wb_rd         = '0;
      drain_req     = 1'b0;
      flush         = 1'b0;
   endtask

   task automatic issue_wr(input int rd);
      issue_valid = 1'b1;
      issue_rd    = AW'(rd);
      issue_rd_wr = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      chk("reset_busy_mask", busy_mask, 0);
      chk("reset_outstanding", outstanding, 0);
      chk("reset_err", err_underflow, 0);
      chk("reset_drain_done", drain_done, 0);
      tick();
      rst = 1'b0;

      // RAW hazard on r5 and its release by writeback
      issue_wr(5);
      #2 chk("rd5_ready", issue_ready, 1);
      tick();
      issue_rd_wr = 1'b0; issue_rs = 5'd5; issue_rs_used = 1'b1;
      #2 chk("rs5_hazard", issue_ready, 0);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd5;
      #2 chk("rs5_wb_cycle", issue_ready, BYP);
      tick();
      wb_valid = 1'b0;
      #2 chk("rs5_after_wb", issue_ready, 1);
      tick();
      idle();

      // Counter saturation on r7
      issue_wr(7);
      repeat (3) tick();
      #2 chk("rd7_outstanding3", outstanding, 3);
      chk("rd7_full_block", issue_ready, 0);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd7;
      #2 chk("rd7_wb_cycle", issue_ready, 0);
      tick();
      wb_valid = 1'b0;
      #2 chk("rd7_after_wb", issue_ready, 1);
      tick();
      idle();
      wb_valid = 1'b1; wb_rd = 5'd7;
      repeat (3) tick();
      idle();
      #2 chk("rd7_cleared", outstanding, 0);

      // Same-cycle issue and writeback on r9
      issue_wr(9);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd9;
      #2 chk("rd9_ready", issue_ready, 1);
      tick();
      idle();
      #2 chk("rd9_busy", busy_mask[9], 1);
      chk("rd9_outstanding", outstanding, 1);
      wb_valid = 1'b1; wb_rd = 5'd9;
      tick();
      idle();

      // Writebacks to r0 are harmless; to an idle register they flag underflow
      wb_valid = 1'b1; wb_rd = 5'd0;
      repeat (2) tick();
      wb_valid = 1'b0;
      #2 chk("wb_r0_no_err", err_underflow, 0);
      wb_valid = 1'b1; wb_rd = 5'd12;
      tick();
      wb_valid = 1'b0;
      #2 chk("wb_r12_err", err_underflow, 1);
      repeat (2) tick();
      chk("wb_r12_sticky", err_underflow, 1);

      // Drain with two pending writes
      issue_wr(3); tick();
      issue_wr(4); tick();
      idle();
      #2 chk("drain_outstanding2", outstanding, 2);
      drain_req = 1'b1;
      tick();
      issue_wr(6);
      #2 chk("drain_blocks_issue", issue_ready, 0);
      issue_valid = 1'b0; issue_rd_wr = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd3; tick();
      wb_rd = 5'd4; tick();
      wb_valid = 1'b0;
      #2 chk("drain_zero", outstanding, 0);
      chk("drain_not_yet", drain_done, 0);
      tick();
      #2 chk("drain_done_pulse", drain_done, 1);
      drain_req = 1'b0;
      tick();
      #2 chk("drain_done_low", drain_done, 0);
      chk("run_after_drain", issue_ready, 1);

      // Flush with four pending writes, then reset in the middle of a drain
      for (int r = 1; r <= 4; r++) begin
         issue_wr(r);
         tick();
      end
      idle();
      #2 chk("flush_pre_out", outstanding, 4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #2 chk("flush_busy", busy_mask, 0);
      chk("flush_out", outstanding, 0);
      issue_wr(10); tick();
      issue_wr(11); tick();
      idle();
      drain_req = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1 chk("rst_async_out", outstanding, 0);
      chk("rst_async_busy", busy_mask, 0);
      tick();
      rst = 1'b0;
      drain_req = 1'b0;
      #2 chk("rst_run_ready", issue_ready, 1);
      chk("rst_err_clear", err_underflow, 0);
      chk("rst_drain_done", drain_done, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter CW, default 2, width of the per-register in-flight counter; MAXP = 2^CW-1.
REQ-004 SHALL have ports: clk input 1, clock; rst input 1, reset (asynchronous, active-high).
REQ-005 SHALL have issue_valid input 1, instruction offered for issue.
REQ-006 SHALL have issue_ready output 1, issue accepted this cycle when high with issue_valid.
REQ-007 SHALL have issue_rs and issue_rt inputs AW, source registers; issue_rs_used and issue_rt_used inputs 1, source actually read.
REQ-008 SHALL have issue_rd input AW, destination; issue_rd_wr input 1, instruction writes issue_rd.
REQ-009 SHALL have wb_valid input 1 and wb_rd input AW, register-file write completing this cycle.
REQ-010 SHALL have drain_req input 1, level request to empty the pipeline; drain_done output 1, one-cycle pulse.
REQ-011 SHALL have flush input 1, discard all in-flight tracking.
REQ-012 SHALL have busy_mask output NREGS, bit i high when count[i] != 0.
REQ-013 SHALL have outstanding output AW+CW, sum of all counts; err_underflow output 1, sticky.

Function
REQ-014 SHALL keep a CW-bit count[i] per register; register 0 is never tracked, so count[0] is always 0.
REQ-015 SHALL signal a source hazard when the source is used, nonzero, and its effective count is nonzero.
REQ-016 SHALL signal a destination hazard when issue_rd_wr is high, issue_rd != 0, and count[issue_rd] == MAXP.
REQ-017 SHALL drive issue_ready = state==RUN and no hazard and no flush, combinationally from registered state and current inputs.
REQ-018 SHALL increment count[issue_rd] at the edge of an accepted issue with issue_rd_wr=1 and issue_rd != 0.
REQ-019 SHALL decrement count[wb_rd] at the edge when wb_valid=1 and wb_rd != 0.
REQ-020 SHALL leave the count unchanged when an accepted issue and a writeback hit the same register in the same cycle.
REQ-021 SHALL ignore a writeback to a register whose count is 0 and set err_underflow, which is cleared only by rst.
REQ-022 SHALL ignore writebacks to register 0 with no error.
REQ-023 SHALL zero all counts at the edge of a flush cycle; issue and writeback in that cycle are ignored.
REQ-024 SHALL implement states RUN and DRAIN, with RUN->DRAIN when drain_req=1.
REQ-025 SHALL take DRAIN->RUN with drain_done=1 for one cycle when outstanding==0 (registered value) or flush=1.
REQ-026 SHALL hold issue_ready=0 in DRAIN while writebacks continue to decrement counts.
REQ-027 SHALL update outstanding in the same edge as counts: +1 on issue-increment, -1 on valid decrement, 0 on flush.

Reset
REQ-028 SHALL on rst asynchronously set all counts 0, state RUN, err_underflow 0, drain_done 0, outstanding 0, and busy_mask 0.

Configuration
REQ-029 SHALL use macro SB_WB_BYPASS_EN.
REQ-030 SHALL with SB_WB_BYPASS_EN defined compute the effective count as count minus 1 when a same-cycle writeback targets the register, so a source whose count is 1 is released in the writeback cycle.
REQ-031 SHALL with SB_WB_BYPASS_EN undefined use the registered count only, so the source is released one cycle after the writeback.

Structure
REQ-032 SHALL place the state enum (RUN, DRAIN) and the defaults for NREGS, AW, and CW in package scoreboard_pkg.
REQ-033 SHALL implement the per-register saturating counter as sub-module sb_reg_counter, instantiated NREGS-1 times.

Verification
REQ-034 SHALL cover: issue rd=5, next cycle issue rs=5 -> issue_ready=0; wb_rd=5 -> ready in the same cycle with bypass, one cycle later without.
REQ-035 SHALL cover: three issues rd=7 with CW=2 -> count 3; a fourth issue rd=7 -> issue_ready=0; one wb rd=7 -> ready next cycle.
REQ-036 SHALL cover: issue rd=9 and wb rd=9 in the same cycle with count 1 -> count stays 1 and busy_mask[9]=1.
REQ-037 SHALL cover: wb rd=12 with count 0 -> err_underflow=1 and stays 1; wb rd=0 -> no error.
REQ-038 SHALL cover: outstanding=2, drain_req -> issue_ready=0; two writebacks -> drain_done pulse in the cycle after outstanding reaches 0, then RUN.
REQ-039 SHALL cover: flush with outstanding=4 -> busy_mask=0 and outstanding=0 next cycle; rst mid-DRAIN -> RUN with all counts 0.
